dmem_mmio_responder: RTL
========================

Name: dmem_mmio_responder

Overview:
Responder end of the core's data-memory port: services the M-stage request (address, write enable, write data) and returns read data in the same cycle.
Decodes each request into one of two regions.
- Word-addressed RAM region.
- Memory-mapped I/O region: GPIO register, free-running cycle counter, sticky status, optional countdown timer.
Sits beside the core in the top-level system, replacing a bare RAM on the data side.

Parameters:
MEM_WORDS, 64, RAM depth in 32-bit words; power of two, ≥4.
MMIO_BASE_HI, 16'hFFFF, value of addr[31:16] that selects the MMIO region.

Ports:
clk  input  1  system clock, all state updates on rising edge.
reset  input  1  asynchronous, active-high; clears all MMIO state.
memwrite  input  1  write strobe for the current request.
addr  input  32  byte address (core ALU result).
writedata  input  32  store data.
readdata  output  32  load data, combinational from addr.
gpio_out  output  32  GPIO register contents.
timer_irq  output  1  mirrors STATUS[1].
err  output  1  mirrors STATUS[0].

Behaviour:
- Region decode: addr[31:16]==MMIO_BASE_HI selects MMIO; every other address selects RAM.
- RAM index = addr[log2(MEM_WORDS)+1:2]. Upper address bits are ignored, so the RAM aliases (wraps).
- Reads are combinational with zero latency. Writes commit on the rising clk edge when memwrite=1. A read in the following cycle returns the new value; no same-cycle bypass.
- Misaligned access (addr[1:0]≠0) in either region: write suppressed, readdata=0, STATUS[0] set at the next edge.
- Reset does not clear RAM. RAM contents are X until written.
- MMIO map, as offset addr[15:0]:
  - 0x00 GPIO: read/write, reset 0.
  - 0x04 CYCLE: read-only; +1 every cycle, wraps at 2^32; reset 0. Reads return the pre-increment value.
  - 0x08 STATUS: bit0 err, bit1 timer_done, other bits read 0. Writing 1 to a bit clears it (W1C). A set event in the same cycle as a W1C wins (bit stays 1).
  - 0x0C TIMER_LOAD: write-only, reads 0.
  - 0x10 TIMER_COUNT: read-only.
- A write to a read-only offset or an unmapped offset is ignored and sets STATUS[0]. Reads of unmapped offsets return 0 with no error.
- Timer FSM with states IDLE, RUN, DONE; reset state IDLE, count 0.
  - Writing N≠0 to LOAD in any state → RUN with count=N.
  - Writing 0 to LOAD → DONE next edge.
  - In RUN, count decrements by 1 per cycle. On the edge where count goes 1→0: enter DONE and set STATUS[1].
  - A LOAD write in the same cycle as expiry wins: the timer reloads and STATUS[1] is not set.
  - In DONE, W1C of STATUS[1] → IDLE.
- Reset asserted mid-operation immediately forces all of the following:
  - GPIO=0, CYCLE=0, STATUS=0.
  - Timer IDLE, count 0.
  - Outputs gpio_out=0, timer_irq=0, err=0.
  - readdata still follows addr.

Optional Feature:
MMIO_TIMER_EN.
- Defined: timer FSM, LOAD/COUNT registers and STATUS[1] are present as described above.
- Undefined: no timer logic is built. Offsets 0x0C and 0x10 behave as unmapped (reads 0; writes set STATUS[0]). STATUS[1] and timer_irq are tied 0.

Decomposition:
- Shared package dmem_pkg holds:
  - MMIO offset constants: OFF_GPIO, OFF_CYCLE, OFF_STATUS, OFF_TLOAD, OFF_TCOUNT.
  - STATUS bit indices.
  - Timer state typedef: T_IDLE, T_RUN, T_DONE.
- Natural sub-module: mmio_timer, containing the FSM and down-counter.
  - Inputs: load strobe, load value, clear strobe.
  - Outputs: count, expire pulse, state.
  - Instantiated only under MMIO_TIMER_EN.

Test Plan:
- RAM round trip: write 0xDEADBEEF @0x00000010 → next cycle read @0x10 = 0xDEADBEEF. With MEM_WORDS=64, a read @0x00000110 also = 0xDEADBEEF (alias).
- Misaligned: write 0x12345678 @0x00000012 → RAM word 4 unchanged, readdata=0, err=1. Write 0x1 @0xFFFF0008 → err=0.
- Cycle counter: release reset, read 0xFFFF0004 after 10 edges = 10. Preload check: CYCLE wraps 0xFFFFFFFF→0.
- GPIO/RO protection: write 0xA5 @0xFFFF0000 → gpio_out=0xA5. Write @0xFFFF0004 → CYCLE unaffected, err=1.
- Timer (MMIO_TIMER_EN): write 3 @0xFFFF000C → COUNT reads 3,2,1 on successive cycles, then timer_irq=1. W1C 0x2 → timer_irq=0, FSM IDLE. Reload on the expiry cycle → no irq.
- Reset mid-run: timer RUN with count 5 and GPIO=0xFF, assert reset between edges → gpio_out=0, timer_irq=0, COUNT=0 immediately. RAM contents retained.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: MMIO offsets, STATUS bits, timer states.
package dmem_pkg;

    localparam logic [15:0] OFF_GPIO   = 16'h0000;
    localparam logic [15:0] OFF_CYCLE  = 16'h0004;
    localparam logic [15:0] OFF_STATUS = 16'h0008;
    localparam logic [15:0] OFF_TLOAD  = 16'h000C;
    localparam logic [15:0] OFF_TCOUNT = 16'h0010;

    localparam int unsigned STATUS_ERR   = 0;
    localparam int unsigned STATUS_TIMER = 1;

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_DONE} timer_state_t;

endpackage

// File: rtl/mmio_timer.sv
// Countdown timer: load/run/expire FSM with a 32-bit down-counter.
// Only instantiated when MMIO_TIMER_EN is defined.
module mmio_timer
    import dmem_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [31:0]  load_value,
    input  logic         clear,
    output logic [31:0]  count,
    output logic         expire,
    output timer_state_t state
);

    timer_state_t state_q, state_d;
    logic [31:0]  count_q, count_d;

    // State and counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= T_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next state: a load always wins, including over an expiry in the same cycle.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        expire  = 1'b0;
        if (load) begin
            if (load_value != 32'd0) begin
                state_d = T_RUN;
                count_d = load_value;
            end else begin
                state_d = T_DONE;
                count_d = '0;
            end
        end else begin
            case (state_q)
                T_RUN: begin
                    count_d = count_q - 32'd1;
                    if (count_q == 32'd1) begin
                        state_d = T_DONE;
                        expire  = 1'b1;
                    end
                end
                T_DONE: begin
                    if (clear) state_d = T_IDLE;
                end
                default: ;
            endcase
        end
    end

    assign count = count_q;
    assign state = state_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-side responder: word RAM plus MMIO block (GPIO, cycle counter, W1C status, timer).
// Define MMIO_TIMER_EN to build the countdown timer at offsets 0x0C/0x10.
module dmem_mmio_responder
    import dmem_pkg::*;
#(
    parameter int unsigned MEM_WORDS    = 64,
    parameter logic [15:0] MMIO_BASE_HI = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] gpio_out,
    output logic        timer_irq,
    output logic        err
);

    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0]    mem [MEM_WORDS];
    logic [31:0]    gpio_q, cycle_q;
    logic [1:0]     status_q, status_d;
    logic           is_mmio, aligned;
    logic [15:0]    off;
    logic [AW-1:0]  idx;
    logic           wr_ram, wr_mmio, wr_gpio, wr_status, wr_tload, mmio_writable, err_event;
    logic           timer_set;
    logic [31:0]    tcount_rd;

    assign is_mmio = (addr[31:16] == MMIO_BASE_HI);
    assign aligned = (addr[1:0] == 2'b00);
    assign off     = addr[15:0];
    assign idx     = addr[AW+1:2];

`ifdef MMIO_TIMER_EN
    logic [31:0]  timer_count;
    logic         timer_expire;
    timer_state_t timer_state;

    mmio_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_tload),
        .load_value (writedata),
        .clear      (wr_status & writedata[STATUS_TIMER]),
        .count      (timer_count),
        .expire     (timer_expire),
        .state      (timer_state)
    );

    assign wr_tload  = wr_mmio & (off == OFF_TLOAD);
    assign timer_set = timer_expire;
    assign tcount_rd = (timer_state == T_RUN) ? timer_count : 32'd0;
`else
    assign wr_tload  = 1'b0;
    assign timer_set = 1'b0;
    assign tcount_rd = 32'd0;
`endif

    // Write decode; there is no read strobe, so only stores can raise an error.
    always_comb begin
        wr_ram        = memwrite & aligned & ~is_mmio;
        wr_mmio       = memwrite & aligned & is_mmio;
        wr_gpio       = wr_mmio & (off == OFF_GPIO);
        wr_status     = wr_mmio & (off == OFF_STATUS);
        mmio_writable = (off == OFF_GPIO) | (off == OFF_STATUS) | wr_tload;
        err_event     = (memwrite & ~aligned) | (wr_mmio & ~mmio_writable);
    end

    // Combinational read mux; misaligned addresses read as zero.
    always_comb begin
        readdata = '0;
        if (aligned) begin
            if (!is_mmio) begin
                readdata = mem[idx];
            end else begin
                case (off)
                    OFF_GPIO:   readdata = gpio_q;
                    OFF_CYCLE:  readdata = cycle_q;
                    OFF_STATUS: readdata = {30'd0, status_q};
`ifdef MMIO_TIMER_EN
                    OFF_TCOUNT: readdata = tcount_rd;
`endif
                    default:    readdata = '0;
                endcase
            end
        end
    end

    // W1C status; a set event in the same cycle beats the clear.
    always_comb begin
        status_d               = status_q;
        status_d[STATUS_ERR]   = err_event |
                                 (status_q[STATUS_ERR] & ~(wr_status & writedata[STATUS_ERR]));
        status_d[STATUS_TIMER] = timer_set |
                                 (status_q[STATUS_TIMER] & ~(wr_status & writedata[STATUS_TIMER]));
    end

    // RAM array; intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ram) mem[idx] <= writedata;
    end

    // MMIO registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gpio_q   <= '0;
            cycle_q  <= '0;
            status_q <= '0;
        end else begin
            if (wr_gpio) gpio_q <= writedata;
            cycle_q  <= cycle_q + 32'd1;
            status_q <= status_d;
        end
    end

    assign gpio_out  = gpio_q;
    assign timer_irq = status_q[STATUS_TIMER];
    assign err       = status_q[STATUS_ERR];

    // Keep tcount_rd referenced in builds without the timer.
    logic unused_tcount;
    assign unused_tcount = ^tcount_rd;

endmodule
